// File: rtl/addsub_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_acc_ctrl_pkg
//  Description : Shared definitions for the add/sub accumulator controller:
//                operation encodings, FSM state encodings and default width.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_acc_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

endpackage : addsub_acc_ctrl_pkg
`default_nettype wire

// File: rtl/addsub_acc_ctrl_addsub_core.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_core
//  Description : Combinational WIDTH-bit ripple-carry adder/subtractor.
//                y is XORed with cin, so cin=1 yields x + ~y + 1 = x - y.
//  Ports       : x_i, y_i   - operands
//                cin_i      - carry-in / subtract select
//                sum_o      - WIDTH-bit result
//                cout_o     - carry out of the MSB
//                v_o        - signed overflow (carry into MSB ^ carry out)
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             v_o
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_y;

    assign w_y        = y_i ^ {WIDTH{cin_i}};
    assign w_carry[0] = cin_i;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign sum_o[i]       = x_i[i] ^ w_y[i] ^ w_carry[i];
            assign w_carry[i+1]   = (x_i[i] & w_y[i]) | (w_carry[i] & (x_i[i] ^ w_y[i]));
        end
    endgenerate

    assign cout_o = w_carry[WIDTH];
    assign v_o    = w_carry[WIDTH] ^ w_carry[WIDTH-1];

endmodule : addsub_core
`default_nettype wire

// File: rtl/addsub_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_acc_ctrl
//  Description : Accumulator and controller around addsub_core. Accepts
//                LOAD/ADD/SUB/CLR requests over valid/ready, updates the
//                accumulator one cycle later and presents the result with
//                N/Z/C/V and sticky-V flags over a second valid/ready port.
//  Ports       : clk, rst (sync, active-high)
//                in_valid/in_ready/in_op/in_operand   - request side
//                out_valid/out_ready/out_acc/out_n/out_z/out_c/out_v/
//                out_sticky_v                          - result side
//  Options     : ADDSUB_ACC_SATURATE_EN - clamp acc on ADD/SUB overflow
//                instead of wrapping (flags still report raw overflow).
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_acc_ctrl
    import addsub_acc_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic             out_sticky_v
);

    state_e           state_q,   state_d;
    op_e              op_q,      op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
    logic             sticky_q,  sticky_d;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_arith;
    logic             w_cout;
    logic             w_v;
    logic             w_cin;

    assign w_cin = (op_q == OP_SUB);

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x_i    (acc_q),
        .y_i    (operand_q),
        .cin_i  (w_cin),
        .sum_o  (w_sum),
        .cout_o (w_cout),
        .v_o    (w_v)
    );

`ifdef ADDSUB_ACC_SATURATE_EN
    // Overflow direction follows the old sign: a positive acc can only
    // overflow upward, a negative one downward.
    assign w_arith = w_v ? (acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}})
                         : w_sum;
`else
    assign w_arith = w_sum;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        n_d       = n_q;
        z_d       = z_q;
        c_d       = c_q;
        v_d       = v_q;
        sticky_d  = sticky_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_EXEC;
                    op_d      = op_e'(in_op);
                    operand_d = in_operand;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                case (op_q)
                    OP_LOAD: begin
                        acc_d    = operand_q;
                        c_d      = 1'b0;
                        v_d      = 1'b0;
                        sticky_d = 1'b0;
                    end
                    OP_CLR: begin
                        acc_d    = '0;
                        c_d      = 1'b0;
                        v_d      = 1'b0;
                        sticky_d = 1'b0;
                    end
                    default: begin
                        acc_d    = w_arith;
                        c_d      = w_cout;
                        v_d      = w_v;
                        sticky_d = sticky_q | w_v;
                    end
                endcase
                n_d = acc_d[WIDTH-1];
                z_d = (acc_d == '0);
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            operand_q <= '0;
            acc_q     <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            z_q       <= z_d;
            c_q       <= c_d;
            v_q       <= v_d;
            sticky_q  <= sticky_d;
        end
    end

    // in_ready must drop combinationally while reset is asserted.
    assign in_ready     = (state_q == S_IDLE) && !rst;
    assign out_valid    = (state_q == S_RESP);
    assign out_acc      = acc_q;
    assign out_n        = n_q;
    assign out_z        = z_q;
    assign out_c        = c_q;
    assign out_v        = v_q;
    assign out_sticky_v = sticky_q;

endmodule : addsub_acc_ctrl
`default_nettype wire

// File: tb/tb_addsub_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_acc_ctrl
//  Description : Self-checking scoreboard bench for addsub_acc_ctrl (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_acc_ctrl;

    localparam int W = 4;
    localparam logic [1:0] C_LOAD = 2'b00;
    localparam logic [1:0] C_ADD  = 2'b01;
    localparam logic [1:0] C_SUB  = 2'b10;
    localparam logic [1:0] C_CLR  = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_operand;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_acc;
    logic         out_n, out_z, out_c, out_v, out_sticky_v;

    int n_tests = 0;
    int n_fail  = 0;

    // expected {acc, n, z, c, v, sticky}
    logic [W+4:0] sb_q[$];
    logic [W-1:0] m_acc;
    logic         m_sticky;

    addsub_acc_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_operand   (in_operand),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_acc      (out_acc),
        .out_n        (out_n),
        .out_z        (out_z),
        .out_c        (out_c),
        .out_v        (out_v),
        .out_sticky_v (out_sticky_v)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: flags from operand signs, not from internal carries.
    task automatic model(input logic [1:0] op, input logic [W-1:0] opnd);
        logic [W:0]   full;
        logic [W-1:0] res;
        logic         c, v;
        c = 1'b0; v = 1'b0; res = '0; full = '0;
        case (op)
            C_LOAD: begin res = opnd; m_sticky = 1'b0; end
            C_CLR:  begin res = '0;   m_sticky = 1'b0; end
            C_ADD: begin
                full = {1'b0, m_acc} + {1'b0, opnd};
                res  = full[W-1:0];
                c    = full[W];
                v    = (m_acc[W-1] == opnd[W-1]) && (res[W-1] != m_acc[W-1]);
            end
            default: begin
                full = {1'b0, m_acc} + {1'b0, ~opnd} + 1;
                res  = full[W-1:0];
                c    = full[W];
                v    = (m_acc[W-1] != opnd[W-1]) && (res[W-1] != m_acc[W-1]);
            end
        endcase
`ifdef ADDSUB_ACC_SATURATE_EN
        if (v) res = m_acc[W-1] ? 4'b1000 : 4'b0111;
`endif
        m_sticky = m_sticky | v;
        m_acc    = res;
        sb_q.push_back({res, res[W-1], (res == '0), c, v, m_sticky});
    endtask

    // Result monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("result_without_request", 32'(sb_q.size()), 32'd1);
            end else begin
                check_eq("result", 32'({out_acc, out_n, out_z, out_c, out_v, out_sticky_v}),
                         32'(sb_q.pop_front()));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after acceptance.
    task automatic send(input logic [1:0] op, input logic [W-1:0] opnd, input bit expect_result);
        int n;
        in_valid = 1'b1; in_op = op; in_operand = opnd;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 20) begin
                check_eq("accept_timeout", 32'(n), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (expect_result) model(op, opnd);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W+4:0] snap;
        int acc_k[$];
        int rise_k[$];
        logic prev_ov;

        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_operand = '0; out_ready = 1'b1;
        m_acc = '0; m_sticky = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_outputs", 32'({out_valid, out_acc, out_n, out_z, out_c, out_v, out_sticky_v}), 32'd0);
        check_eq("reset_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Wrap ADD
        send(C_LOAD, 4'd5, 1);
        send(C_ADD,  4'd2, 1);
        send(C_ADD,  4'd1, 1);
        drain();
        // Zero SUB
        send(C_LOAD, 4'd3, 1);
        send(C_SUB,  4'd3, 1);
        drain();
        // SUB overflow then CLR
        send(C_LOAD, 4'b1000, 1);
        send(C_SUB,  4'd1, 1);
        send(C_CLR,  4'd9, 1);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send(C_LOAD, 4'd6, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("bp_valid_rise", 32'(out_valid), 32'd1);
        snap = {out_acc, out_n, out_z, out_c, out_v, out_sticky_v};
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_ready_low", 32'(in_ready), 32'd0);
            check_eq("bp_valid_hold", 32'(out_valid), 32'd1);
            check_eq("bp_data_hold", 32'({out_acc, out_n, out_z, out_c, out_v, out_sticky_v}), 32'(snap));
            if (i == 1) begin in_valid = 1'b1; in_op = C_ADD; in_operand = 4'd7; end
            if (i == 2) in_valid = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_idle_ready", 32'(in_ready), 32'd1);
        check_eq("bp_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send(C_ADD, 4'd1, 1);
        drain();

        // Latency / throughput with continuous in_valid
        in_valid = 1'b1; in_op = C_ADD; in_operand = 4'd1;
        prev_ov = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) begin
                model(C_ADD, 4'd1);
                acc_k.push_back(k);
            end
            if (out_valid && !prev_ov) rise_k.push_back(k);
            prev_ov = out_valid;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        check_eq("tp_accept_count", 32'(acc_k.size()), 32'd4);
        check_eq("tp_rise_count", 32'(rise_k.size()), 32'd3);
        for (int j = 1; j < acc_k.size(); j++)
            check_eq("tp_spacing", 32'(acc_k[j] - acc_k[j-1]), 32'd3);
        for (int j = 0; j < rise_k.size() && j < acc_k.size(); j++)
            check_eq("tp_latency", 32'(rise_k[j] - acc_k[j]), 32'd2);
        drain();

        // Reset during EXEC
        send(C_LOAD, 4'd2, 1);
        drain();
        send(C_ADD, 4'd4, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_acc = '0; m_sticky = 1'b0;
        @(negedge clk);
        check_eq("midrst_outputs", 32'({out_valid, out_acc, out_n, out_z, out_c, out_v, out_sticky_v}), 32'd0);
        check_eq("midrst_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check_eq("midrst_no_result", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(C_ADD, 4'd3, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_addsub_acc_ctrl
`default_nettype wire

// File: doc/addsub_acc_ctrl.md
Name: addsub_acc_ctrl

Overview:
- Sequential accumulator and controller wrapped around the team's ripple-carry add/sub datapath.
- Accepts operation/operand requests over a valid/ready handshake and drives the operands and carry-in into the datapath.
- Registers the sum, carry and overflow into an accumulator, and presents the result with N/Z/C/V flags over a second valid/ready handshake.
- Sits directly upstream and downstream of the add/sub stage: it feeds that stage and consumes what it produces.

Parameters:
- WIDTH, 4, data width of the accumulator, operand and result (minimum 2).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_op  input  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- in_operand  input  WIDTH  operand (two's complement).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  WIDTH  accumulator value after the operation.
- out_n  output  1  negative flag, equals out_acc[WIDTH-1].
- out_z  output  1  zero flag, set when out_acc == 0.
- out_c  output  1  carry-out of the MSB; for SUB, 1 means no borrow.
- out_v  output  1  signed overflow of this operation.
- out_sticky_v  output  1  OR of all V flags since the last LOAD/CLR/reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- FSM states: IDLE, EXEC, RESP.
  - IDLE -> EXEC on in_valid && in_ready; in_op and in_operand are captured into internal registers.
  - EXEC -> RESP unconditionally. On this edge acc and all flags are updated and out_valid goes to 1.
  - RESP -> IDLE on out_valid && out_ready.
- in_ready is 1 only in IDLE, and is 0 in any cycle where rst is high.
- Latency: request accepted at edge T0; result visible with out_valid=1 after edge T1. Minimum spacing between accepted requests is 3 cycles.
- While in RESP with out_ready=0, out_valid, out_acc, all flags and out_sticky_v hold stable.
- Datapath connections:
  - x = acc.
  - y = in_operand.
  - cin = 1 for SUB, 0 for ADD.
  - y is XORed with cin, so SUB computes acc + ~operand + 1.
- Flags:
  - C = carry out of bit WIDTH-1.
  - V = carry into MSB XOR carry out of MSB.
  - All arithmetic is modulo 2^WIDTH.
- Per operation:
  - LOAD: acc = operand; C=0, V=0; sticky cleared.
  - CLR: acc = 0; C=0, V=0; sticky cleared.
  - ADD/SUB: acc = WIDTH-bit sum; C and V from the datapath; sticky |= V.
- N and Z are always derived from the new acc.
- Reset values: acc=0, state=IDLE, out_valid=0, out_acc=0, N=0, Z=0, C=0, V=0, sticky=0.
- Reset mid-operation (in EXEC or RESP): the pending operation is discarded and all registers take their reset values on that edge. No result is emitted.
- in_valid while not in IDLE is ignored. The upstream side must hold its request until in_ready.

Optional Feature:
- Macro: ADDSUB_ACC_SATURATE_EN.
- Defined: on ADD/SUB with V=1, acc is clamped instead of wrapping.
  - Clamp to the maximum positive value 0111..1 if the old acc MSB was 0.
  - Clamp to the minimum negative value 100..0 if the old acc MSB was 1.
  - V, C and sticky still report the raw overflow and carry.
  - N and Z follow the clamped acc.
- Undefined: acc wraps modulo 2^WIDTH.

Decomposition:
- Shared package/header:
  - op encodings OP_LOAD, OP_ADD, OP_SUB, OP_CLR.
  - FSM state encodings S_IDLE, S_EXEC, S_RESP.
  - default WIDTH.
- One natural sub-module: addsub_core, a parameterised combinational WIDTH-bit add/sub producing sum, cout and v. It is instantiated once inside the block.

Test Plan:
- Wrap ADD: reset; LOAD 5; ADD 2 -> acc=0111, N0 Z0 C0 V0. Then ADD 1 -> acc=1000, N1 Z0 C0 V1, sticky=1 (with the macro: acc=0111, N0, V1).
- Zero SUB: LOAD 3; SUB 3 -> acc=0000, Z1 C1 V0 N0; sticky=0 after the LOAD.
- SUB overflow: LOAD 1000; SUB 1 -> acc=0111, C1 V1 N0, sticky=1 (with the macro: acc=1000, N1). Then CLR -> acc=0, Z1, sticky=0.
- Backpressure: hold out_ready=0 for 4 cycles in RESP -> out_valid=1 and data stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Latency and throughput: back-to-back in_valid with out_ready tied high -> a request is accepted every 3rd cycle, and out_valid rises exactly 2 edges after acceptance.
- Reset mid-op: assert rst for 1 cycle while in EXEC after ADD 4 on acc=2 -> next cycle acc=0, all flags 0, out_valid=0, in_ready=1, no result emitted.
